// File: rtl/pixel_write_scheduler.sv
// Arbitrates the single frame-buffer write port between a grid-clear sweep,
// the load path and the simulation path; one registered pixel per cycle.
module pixel_write_scheduler #(
  parameter int unsigned GRID_W       = 4,
  parameter int unsigned GRID_H       = 4,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear_req,
  output logic       clear_busy,
  output logic       clear_done,
  input  logic       ld_valid,
  output logic       ld_ready,
  input  logic [7:0] ld_x,
  input  logic [7:0] ld_y,
  input  logic [2:0] ld_colour,
  input  logic       sim_valid,
  output logic       sim_ready,
  input  logic [7:0] sim_x,
  input  logic [7:0] sim_y,
  input  logic [2:0] sim_colour,
  output logic [7:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       drop
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic [7:0] W_LIM  = 8'(GRID_W);
  localparam logic [7:0] H_LIM  = 8'(GRID_H);
  localparam logic [7:0] X_LAST = 8'(GRID_W - 1);
  localparam logic [7:0] Y_LAST = 8'(GRID_H - 1);

  logic [0:0] state;
  logic [7:0] cx;
  logic [7:0] cy;
  logic       last_sim;

  logic       blocked;
  logic       grant_ld;
  logic       grant_sim;
  logic [7:0] sel_x;
  logic [7:0] sel_y;
  logic [2:0] sel_colour;
  logic       in_range;

  // last_sim=1 means sim won the previous acceptance, so ld wins the next tie.
  always_comb begin
    blocked    = (state == CLEAR) || clear_req;
    grant_ld   = !blocked && ld_valid  && (!sim_valid || last_sim);
    grant_sim  = !blocked && sim_valid && (!ld_valid  || !last_sim);
    sel_x      = grant_sim ? sim_x      : ld_x;
    sel_y      = grant_sim ? sim_y      : ld_y;
    sel_colour = grant_sim ? sim_colour : ld_colour;
    in_range   = (sel_x < W_LIM) && (sel_y < H_LIM);
    ld_ready   = grant_ld;
    sim_ready  = grant_sim;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cx         <= '0;
      cy         <= '0;
      last_sim   <= 1'b1;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      drop       <= 1'b0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      vga_plot   <= 1'b0;
      drop       <= 1'b0;
      clear_done <= 1'b0;
      // Delayed copy of the state so busy lines up with the sweep's plot strobes.
      clear_busy <= (state == CLEAR);
      if (state == CLEAR) begin
        vga_x      <= cx;
        vga_y      <= cy;
        vga_colour <= CLEAR_COLOUR;
        vga_plot   <= 1'b1;
        if (cx == X_LAST) begin
          cx <= '0;
          if (cy == Y_LAST) begin
            cy         <= '0;
            state      <= IDLE;
            clear_done <= 1'b1;
          end else begin
            cy <= cy + 8'd1;
          end
        end else begin
          cx <= cx + 8'd1;
        end
      end else if (clear_req) begin
        state <= CLEAR;
        cx    <= '0;
        cy    <= '0;
      end else if (grant_ld || grant_sim) begin
        last_sim <= grant_sim;
        if (in_range) begin
          vga_x      <= sel_x;
          vga_y      <= sel_y;
          vga_colour <= sel_colour;
          vga_plot   <= 1'b1;
        end else begin
          drop <= 1'b1;
        end
      end
    end
  end

endmodule
